// File: rtl/stream_pkg.sv
// Shared definitions for the valid/ready stream steering blocks:
// selection-mode codes, select-index width and channel-slice offsets.
package stream_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // A channel index is never narrower than one bit, even for two channels.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int chan_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: grants the first requester at or above the pointer
// (cyclically) and moves the pointer just past the winner on advance.
module rr_arbiter_n
    import stream_pkg::*;
#(
    parameter int N    = 2,
    parameter int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] ptr;
    logic [SELW:0]   sum;
    logic [SELW-1:0] pos;
    logic            found;

    // Scan N positions starting at the pointer; the first request found wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (SELW+1)'(off);
            if (sum >= (SELW+1)'(N)) begin
                sum = sum - (SELW+1)'(N);
            end
            pos = sum[SELW-1:0];
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                found      = 1'b1;
            end
        end
    end

    // Priority only rotates on an actual transfer, never on idle or stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (idx == SELW'(N - 1)) ? '0 : idx + SELW'(1);
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-input valid/ready multiplexer with a single registered output stage;
// channel chosen by an explicit select or by round-robin arbitration.
module stream_mux_n
    import stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 2,
    parameter int MODE  = MODE_SEL,
    localparam int SELW = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] win_data;
    logic             load;
    logic             accept;

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter_n #(.N(N), .SELW(SELW)) u_arb (
                .clk     (clk),
                .rst_n   (rst_n),
                .req     (in_valid),
                .advance (accept),
                .grant   (grant),
                .idx     (grant_idx)
            );
        end else begin : g_sel
            // A select at or beyond N matches no channel, so nothing is granted.
            always_comb begin
                grant     = '0;
                grant_idx = sel;
                for (int i = 0; i < N; i++) begin
                    if (sel == SELW'(i)) begin
                        grant[i] = in_valid[i];
                    end
                end
            end
        end
    endgenerate

    assign load     = !out_valid || out_ready;
    assign in_ready = grant & {N{load & rst_n}};
    assign accept   = |in_ready;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win_data = in_data[chan_lsb(i, WIDTH) +: WIDTH];
            end
        end
    end

    // Output register: refill whenever the slot is free or being drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_src   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed scoreboard bench for stream_mux_n: a select-driven and a
// round-robin instance, both three channels of 32 bits.
module tb_stream_mux_n;
    import stream_pkg::*;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int SW = 2;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N*W-1:0] in_data [2];
    logic [N-1:0]   in_valid [2];
    logic [N-1:0]   in_ready [2];
    logic [SW-1:0]  sel [2];
    logic [W-1:0]   out_data [2];
    logic [SW-1:0]  out_src [2];
    logic           out_valid [2];
    logic           out_ready [2];

    word_t sb0[$];
    word_t sb1[$];
    int compared   = 0;
    int mismatched = 0;

    stream_mux_n #(.WIDTH(W), .N(N), .MODE(MODE_SEL)) m0 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .sel(sel[0]),
        .out_data(out_data[0]), .out_src(out_src[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0])
    );

    stream_mux_n #(.WIDTH(W), .N(N), .MODE(MODE_RR)) m1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .sel(sel[1]),
        .out_data(out_data[1]), .out_src(out_src[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1])
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [N-1:0] v, input logic [W-1:0] d0,
                                 input logic [W-1:0] d1, input logic [W-1:0] d2,
                                 input logic [SW-1:0] s, input logic ordy);
        in_valid[k]  = v;
        in_data[k]   = {d2, d1, d0};
        sel[k]       = s;
        out_ready[k] = ordy;
    endtask

    // Compare the output register against the scoreboard head; pop it if it drains.
    task automatic checkDut(input int k);
        word_t front;
        logic  has;
        front = '0;
        has   = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        if (has) front = (k == 0) ? sb0[0] : sb1[0];
        checkOutput($sformatf("m%0d.out_valid", k), W'(out_valid[k]), W'(has));
        if (has) begin
            checkOutput($sformatf("m%0d.out_data", k), out_data[k], front.d);
            checkOutput($sformatf("m%0d.out_src", k), W'(out_src[k]), W'(front.s));
            if (out_ready[k]) begin
                if (k == 0) void'(sb0.pop_front());
                else        void'(sb1.pop_front());
            end
        end
    endtask

    task automatic pushAccepted(input int k, input logic [N-1:0] er);
        word_t w;
        for (int i = 0; i < N; i++) begin
            if (er[i] && in_valid[k][i]) begin
                w.d = in_data[k][i*W +: W];
                w.s = SW'(i);
                if (k == 0) sb0.push_back(w);
                else        sb1.push_back(w);
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] er0, input logic [N-1:0] er1);
        @(negedge clk);
        checkDut(0);
        checkDut(1);
        checkOutput("m0.in_ready", W'(in_ready[0]), W'(er0));
        checkOutput("m1.in_ready", W'(in_ready[1]), W'(er1));
        pushAccepted(0, er0);
        pushAccepted(1, er1);
        @(posedge clk);
        #1;
    endtask

    task automatic resetPhase(input int n);
        rst_n = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checkOutput("rst.m0.in_ready", W'(in_ready[0]), '0);
            checkOutput("rst.m1.in_ready", W'(in_ready[1]), '0);
            @(posedge clk);
            #1;
        end
        sb0.delete();
        sb1.delete();
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("rst.m%0d.out_valid", k), W'(out_valid[k]), '0);
            checkOutput($sformatf("rst.m%0d.out_data", k), out_data[k], '0);
            checkOutput($sformatf("rst.m%0d.out_src", k), W'(out_src[k]), '0);
        end
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: run did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 3'b111, 32'h1, 32'h2, 32'h3, 2'd0, 1'b1);
        applyStimulus(1, 3'b111, 32'h4, 32'h5, 32'h6, 2'd0, 1'b1);
        resetPhase(2);
        rst_n = 1'b1;
        applyStimulus(0, 3'b000, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1);
        applyStimulus(1, 3'b000, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1);
        cycle(3'b000, 3'b000);

        $display("[TB] select mode: sel=2");
        applyStimulus(0, 3'b100, 32'h0, 32'h0, 32'hDEADBEEF, 2'd2, 1'b1);
        cycle(3'b100, 3'b000);
        applyStimulus(0, 3'b000, 32'h0, 32'h0, 32'h0, 2'd2, 1'b1);
        cycle(3'b000, 3'b000);
        cycle(3'b000, 3'b000);

        $display("[TB] select mode: out-of-range sel, then back-to-back");
        applyStimulus(0, 3'b111, 32'hA, 32'hB, 32'hC, 2'd3, 1'b1);
        cycle(3'b000, 3'b000);
        cycle(3'b000, 3'b000);
        applyStimulus(0, 3'b111, 32'hA, 32'hB, 32'hC, 2'd0, 1'b1);
        cycle(3'b001, 3'b000);
        applyStimulus(0, 3'b111, 32'hA, 32'hB, 32'hC, 2'd1, 1'b1);
        cycle(3'b010, 3'b000);
        applyStimulus(0, 3'b000, 32'h0, 32'h0, 32'h0, 2'd1, 1'b1);
        cycle(3'b000, 3'b000);
        cycle(3'b000, 3'b000);

        $display("[TB] select mode: stall and release");
        applyStimulus(0, 3'b001, 32'h11, 32'h0, 32'h0, 2'd0, 1'b1);
        cycle(3'b001, 3'b000);
        applyStimulus(0, 3'b010, 32'h0, 32'h22, 32'h0, 2'd1, 1'b0);
        repeat (3) cycle(3'b000, 3'b000);
        applyStimulus(0, 3'b010, 32'h0, 32'h22, 32'h0, 2'd1, 1'b1);
        cycle(3'b010, 3'b000);
        applyStimulus(0, 3'b000, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1);
        cycle(3'b000, 3'b000);
        cycle(3'b000, 3'b000);

        $display("[TB] round-robin: all valid");
        applyStimulus(1, 3'b111, 32'hA0, 32'hA1, 32'hA2, 2'd0, 1'b1);
        cycle(3'b000, 3'b001);
        cycle(3'b000, 3'b010);
        cycle(3'b000, 3'b100);
        cycle(3'b000, 3'b001);
        cycle(3'b000, 3'b010);
        cycle(3'b000, 3'b100);
        applyStimulus(1, 3'b000, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1);
        cycle(3'b000, 3'b000);

        $display("[TB] round-robin: idle cycle keeps pointer");
        applyStimulus(1, 3'b010, 32'h0, 32'hB1, 32'h0, 2'd0, 1'b1);
        cycle(3'b000, 3'b010);
        applyStimulus(1, 3'b000, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1);
        cycle(3'b000, 3'b000);
        applyStimulus(1, 3'b011, 32'hB0, 32'hB1, 32'h0, 2'd0, 1'b1);
        cycle(3'b000, 3'b001);
        applyStimulus(1, 3'b000, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1);
        cycle(3'b000, 3'b000);
        cycle(3'b000, 3'b000);

        $display("[TB] round-robin: reset during stall");
        applyStimulus(1, 3'b010, 32'hC0, 32'hC1, 32'hC2, 2'd0, 1'b1);
        cycle(3'b000, 3'b010);
        applyStimulus(1, 3'b001, 32'hC0, 32'hC1, 32'hC2, 2'd0, 1'b0);
        cycle(3'b000, 3'b000);
        resetPhase(1);
        rst_n = 1'b1;
        applyStimulus(1, 3'b111, 32'hD0, 32'hD1, 32'hD2, 2'd0, 1'b1);
        cycle(3'b000, 3'b001);
        applyStimulus(1, 3'b000, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1);
        cycle(3'b000, 3'b000);
        cycle(3'b000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
